// File: rtl/store_commit_queue_pkg.sv
// Shared store-queue types: default depth and the 68-bit store entry.
package store_commit_queue_pkg;

    localparam int SCQ_DEPTH = 8;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  wstrb;
    } store_entry_t;

    localparam int SCQ_ENTRY_W = $bits(store_entry_t);

endpackage

// File: rtl/store_queue_ram.sv
// Store entry storage, DEPTH x 68 bits, payload is never reset.
// Latency: write visible at the next edge, read is combinational.
// Backpressure: none; the owner only writes slots it has allocated.
module store_queue_ram
    import store_commit_queue_pkg::*;
#(
    parameter int DEPTH = SCQ_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_idx,
    input  logic [SCQ_ENTRY_W-1:0] wr_dat,
    input  logic [AW-1:0]          rd_idx,
    output logic [SCQ_ENTRY_W-1:0] rd_dat
);

    logic [SCQ_ENTRY_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_idx];

endmodule

// File: rtl/store_commit_queue.sv
// In-order store queue: allocate at tail, commit at cptr, drain to D-cache from head.
// Latency: a committed store requests the D-cache the cycle after its commit edge.
// Backpressure: push_ready drops when full or flushing; drain stalls while dc_ack is low.
module store_commit_queue
    import store_commit_queue_pkg::*;
#(
    parameter int DEPTH = SCQ_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_valid,
    input  logic [31:0]            push_addr,
    input  logic [31:0]            push_data,
    input  logic [3:0]             push_wstrb,
    output logic                   push_ready,
    input  logic                   fire0,
    input  logic                   fire1,
    input  logic                   flush,
    output logic                   dc_req,
    output logic [31:0]            dc_addr,
    output logic [31:0]            dc_data,
    output logic [3:0]             dc_wstrb,
    input  logic                   dc_ack,
    output logic                   full,
    output logic                   empty,
    output logic                   err,
    output logic [$clog2(DEPTH):0] cmt_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0] head_q;
    logic [PW-1:0] cptr_q;
    logic [PW-1:0] tail_q;
    logic          err_q;

    logic [PW-1:0] occ;
    logic [PW-1:0] uncmt;
    logic [PW-1:0] fire_n;
    logic [PW-1:0] cptr_post;
    logic          over_commit;
    logic          push_go;
    logic          drain_go;

    store_entry_t  wr_ent;
    store_entry_t  rd_ent;

    assign occ        = tail_q - head_q;
    assign full       = (occ == PW'(DEPTH));
    assign empty      = (occ == '0);
    assign push_ready = !full && !flush;
    assign push_go    = push_valid && push_ready;

    // Commits only cover stores already allocated; a same-cycle push is never committable.
    assign fire_n      = PW'(fire0) + PW'(fire1);
    assign uncmt       = tail_q - cptr_q;
    assign over_commit = (fire_n > uncmt);
    assign cptr_post   = over_commit ? tail_q : (cptr_q + fire_n);

    // dc_req depends on registered pointers only, so dc_ack never reaches it combinationally.
    assign dc_req   = (head_q != cptr_q);
    assign drain_go = dc_req && dc_ack;
    assign cmt_cnt  = cptr_q - head_q;
    assign err      = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q <= '0;
            cptr_q <= '0;
            tail_q <= '0;
            err_q  <= 1'b0;
        end else begin
            head_q <= head_q + PW'(drain_go);
            cptr_q <= cptr_post;
            // Flush drops everything past the post-commit boundary.
            if (flush) begin
                tail_q <= cptr_post;
            end else if (push_go) begin
                tail_q <= tail_q + PW'(1);
            end
            if (over_commit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign wr_ent = '{addr: push_addr, data: push_data, wstrb: push_wstrb};

    store_queue_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk    (clk),
        .wr_en  (push_go),
        .wr_idx (tail_q[AW-1:0]),
        .wr_dat (wr_ent),
        .rd_idx (head_q[AW-1:0]),
        .rd_dat (rd_ent)
    );

    assign dc_addr  = rd_ent.addr;
    assign dc_data  = rd_ent.data;
    assign dc_wstrb = rd_ent.wstrb;

endmodule

// File: tb/tb_store_commit_queue.sv
// Directed bench for store_commit_queue with a queue-based scoreboard of pending/committed stores.
module tb_store_commit_queue;
    import store_commit_queue_pkg::*;

    localparam int DEPTH = 8;
    localparam int PW    = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        push_valid;
    logic [31:0] push_addr;
    logic [31:0] push_data;
    logic [3:0]  push_wstrb;
    logic        push_ready;
    logic        fire0;
    logic        fire1;
    logic        flush;
    logic        dc_req;
    logic [31:0] dc_addr;
    logic [31:0] dc_data;
    logic [3:0]  dc_wstrb;
    logic        dc_ack;
    logic        full;
    logic        empty;
    logic        err;
    logic [PW-1:0] cmt_cnt;

    always #5 clk = ~clk;

    store_commit_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .push_valid (push_valid),
        .push_addr  (push_addr),
        .push_data  (push_data),
        .push_wstrb (push_wstrb),
        .push_ready (push_ready),
        .fire0      (fire0),
        .fire1      (fire1),
        .flush      (flush),
        .dc_req     (dc_req),
        .dc_addr    (dc_addr),
        .dc_data    (dc_data),
        .dc_wstrb   (dc_wstrb),
        .dc_ack     (dc_ack),
        .full       (full),
        .empty      (empty),
        .err        (err),
        .cmt_cnt    (cmt_cnt)
    );

    // Scoreboard: pushed-but-uncommitted and committed-but-undrained stores, plus expected pointers.
    store_entry_t  pend[$];
    store_entry_t  cmtq[$];
    logic [PW-1:0] m_head;
    logic [PW-1:0] m_cptr;
    logic [PW-1:0] m_tail;
    logic          m_err;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        pend.delete();
        cmtq.delete();
        m_head = '0;
        m_cptr = '0;
        m_tail = '0;
        m_err  = 1'b0;
    endtask

    task automatic check_outputs(input logic fl);
        int occ;
        occ = pend.size() + cmtq.size();
        chk("dc_req", 32'(dc_req), 32'(cmtq.size() != 0));
        if (cmtq.size() != 0) begin
            chk("dc_addr", dc_addr, cmtq[0].addr);
            chk("dc_data", dc_data, cmtq[0].data);
            chk("dc_wstrb", 32'(dc_wstrb), 32'(cmtq[0].wstrb));
        end
        chk("full", 32'(full), 32'(occ == DEPTH));
        chk("empty", 32'(empty), 32'(occ == 0));
        chk("push_ready", 32'(push_ready), 32'((occ != DEPTH) && !fl));
        chk("cmt_cnt", 32'(cmt_cnt), 32'(cmtq.size()));
        chk("err", 32'(err), 32'(m_err));
        chk("head", 32'(dut.head_q), 32'(m_head));
        chk("cptr", 32'(dut.cptr_q), 32'(m_cptr));
        chk("tail", 32'(dut.tail_q), 32'(m_tail));
    endtask

    // One clock: drive inputs, check at the falling edge, update the model, advance past the rising edge.
    task automatic step(input logic pv, input logic [31:0] pa, input logic [31:0] pd,
                        input logic [3:0] pw, input logic f0, input logic f1,
                        input logic fl, input logic ack);
        int occ;
        int n;
        push_valid = pv;
        push_addr  = pa;
        push_data  = pd;
        push_wstrb = pw;
        fire0      = f0;
        fire1      = f1;
        flush      = fl;
        dc_ack     = ack;
        @(negedge clk);
        check_outputs(fl);
        occ = pend.size() + cmtq.size();
        if (ack && cmtq.size() != 0) begin
            void'(cmtq.pop_front());
            m_head = m_head + 4'd1;
        end
        n = int'(f0) + int'(f1);
        if (n > pend.size()) begin
            m_err = 1'b1;
            n     = pend.size();
        end
        for (int k = 0; k < n; k++) begin
            cmtq.push_back(pend.pop_front());
            m_cptr = m_cptr + 4'd1;
        end
        if (fl) begin
            pend.delete();
            m_tail = m_cptr;
        end else if (pv && occ != DEPTH) begin
            pend.push_back('{addr: pa, data: pd, wstrb: pw});
            m_tail = m_tail + 4'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic f0, input logic f1, input logic ack);
        step(1'b1, a, $urandom(), 4'($urandom_range(15, 1)), f0, f1, 1'b0, ack);
    endtask

    task automatic idle(input logic ack);
        step(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, ack);
    endtask

    task automatic drain_all();
        for (int i = 0; i < 40 && (pend.size() + cmtq.size()) != 0; i++) begin
            step(1'b0, 32'h0, 32'h0, 4'h0, pend.size() > 0, pend.size() > 1, 1'b0, 1'b1);
        end
        chk("drain_done", 32'(pend.size() + cmtq.size()), 32'd0);
    endtask

    // Reset asserted between clock edges so the asynchronous clear is visible before any edge.
    task automatic do_reset();
        push_valid = 1'b0;
        fire0      = 1'b0;
        fire1      = 1'b0;
        flush      = 1'b0;
        dc_ack     = 1'b0;
        #2 rst = 1'b0;
        model_clear();
        #1 check_outputs(1'b0);
        @(negedge clk);
        check_outputs(1'b0);
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        push_valid = 1'b0;
        push_addr  = '0;
        push_data  = '0;
        push_wstrb = '0;
        fire0      = 1'b0;
        fire1      = 1'b0;
        flush      = 1'b0;
        dc_ack     = 1'b0;
        model_clear();
        #1 rst = 1'b0;
        #2 check_outputs(1'b0);
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        check_outputs(1'b0);

        // Three stores, commit one then two, ack held high: in-order back-to-back drain.
        push(32'hA000_0000, 1'b0, 1'b0, 1'b1);
        push(32'hA000_0004, 1'b0, 1'b0, 1'b1);
        push(32'hA000_0008, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) idle(1'b1);

        // Fill to DEPTH (ninth push refused), commit two, drain one.
        for (int i = 0; i < DEPTH + 1; i++) push(32'hB000_0000 + 32'(i * 4), 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        push(32'hB000_0100, 1'b0, 1'b0, 1'b0);
        drain_all();

        // Flush with a fire in the same cycle; the next push must reuse slot 2.
        do_reset();
        for (int i = 0; i < 5; i++) push(32'hC000_0000 + 32'(i * 4), 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hC0FF_EE00, 32'h1234_5678, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b1);
        push(32'hC000_0100, 1'b0, 1'b0, 1'b0);
        drain_all();

        // Long stall: request and payload stay stable, one ack moves head by one.
        for (int i = 0; i < 3; i++) push(32'hD000_0000 + 32'(i * 4), 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) idle(1'b0);
        idle(1'b1);
        idle(1'b0);
        drain_all();

        // Over-commit: two fires with one uncommitted store sets sticky err.
        push(32'hE000_0000, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b0);
        drain_all();
        idle(1'b1);

        // Streaming traffic wraps the pointers, then reset lands mid-drain.
        for (int i = 0; i < 20; i++) push(32'hF000_0000 + 32'(i * 4), i > 0, 1'b0, 1'b1);
        push(32'hF000_0100, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        do_reset();
        idle(1'b0);
        idle(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
